clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Programmable integer clock divider: divides `clk` by N, with N = 2..2^W-1, at exactly 50% duty for both odd and even N.
- Odd N uses a half-period term from a falling-edge register, so the block uses both edges of the single input clock.
- Ratio changes and stop/start are applied only at period boundaries, so the output never has runt pulses.
- Provides a one-cycle `tick` strobe in the `clk` domain for logic that consumes the divided rate synchronously.

Parameters:
- W, 8, width of the ratio field and the internal counter.
- DEFAULT_DIV, 3, active ratio after reset. Must be 2..2^W-1.

Ports:
- clk  input  1  source clock; both edges are used.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable, sampled at `clk` rising edges.
- div_ratio  input  W  requested ratio N.
- ratio_load  input  1  one-cycle request to capture `div_ratio`.
- clk_q  output  1  divided clock.
- tick  output  1  one-cycle pulse at the `clk` rising edge where each clk_q period starts.
- ratio_pending  output  1  a captured ratio is waiting for the next boundary.

Behaviour:
- Reset (asynchronous, both edge domains):
  - cnt = 0, n_act = DEFAULT_DIV, n_pend = 0.
  - clk_q = 0, tick = 0, ratio_pending = 0.
  - Running state = IDLE.
- States:
  - IDLE: clk_q low, cnt held at 0.
  - RUN: counting.
  - STOPPING: `en` has dropped; finish the current period.
- Transitions:
  - IDLE -> RUN at the first rising edge with en = 1. That edge is period start: cnt = 0, tick = 1, clk_q rises.
  - RUN -> STOPPING when en = 0 is sampled mid-period.
  - STOPPING -> IDLE when cnt wraps. No new period starts and clk_q stays low.
  - STOPPING -> RUN if en returns to 1 before the wrap.
  - If en = 0 is sampled exactly at the wrap edge, go straight to IDLE.
- Counter:
  - cnt counts 0..n_act-1 on rising edges, then wraps to 0.
  - The wrap edge is the period boundary.
  - tick is high for the `clk` cycle following each boundary edge, including the IDLE->RUN start.
- Even N:
  - clk_q is driven from the rising-edge register only.
  - High for N/2 `clk` cycles from the boundary edge, then low for N/2.
- Odd N:
  - Rising-edge term p is high for cnt in 0..(N-1)/2-1.
  - Falling-edge term n is p re-registered on the falling edge of `clk`.
  - clk_q = p OR n, giving high time of N/2 cycles (an exact half-cycle fraction).
  - Example, N = 3: high 1.5 cycles, low 1.5 cycles.
- Ratio load:
  - ratio_load = 1 at a rising edge captures div_ratio into n_pend and sets ratio_pending.
  - A later load before the boundary overwrites n_pend (last request wins).
  - Values 0 and 1 are clamped to 2.
- Ratio apply:
  - At the next boundary, or immediately while IDLE, n_act <= n_pend and ratio_pending clears.
  - The new ratio governs the period that starts at that boundary.
  - A load coinciding with a boundary edge is applied at the following boundary.
- No output glitches:
  - clk_q is produced only by registered terms combined with a single OR.
  - The odd-N falling-edge term is forced to 0 whenever n_act is even.
- Reset mid-period: clk_q drops to 0 immediately (asynchronous). This is the only permitted truncated period.

Decomposition:
- Shared clkgen package holds:
  - the W default,
  - the clamp constant MIN_DIV = 2,
  - the state enum {IDLE, RUN, STOPPING}.
- One natural sub-module, `clk_div_phase`, owns the p/n register pair and the OR combination.
  - Inputs: cnt, n_act, run.
  - Output: clk_q.
  - Keeps the dual-edge logic isolated for constraint and lint waivers.
- The parent holds the FSM, the counter, and the ratio shadowing.

Test Plan:
- Reset, then en = 1 with DEFAULT_DIV = 3:
  - clk_q period is 3 clk cycles: high 1.5 cycles, low 1.5 cycles.
  - tick repeats every 3 cycles, aligned to clk_q rising.
- Load ratio 4 mid-period with N = 3:
  - ratio_pending = 1 until the next wrap.
  - The current 3-cycle period completes, then clk_q is high 2 / low 2.
  - No period shorter than 3 cycles occurs.
- Two loads, 6 then 5, within one period:
  - Only 5 takes effect: high 2.5 cycles, low 2.5 cycles.
- Load 0 and load 1:
  - Both are clamped: N = 2, clk_q toggles every cycle.
- en dropped at cnt = 1 with N = 8:
  - clk_q completes its 4 high / 4 low period, then stays low.
  - tick stops.
  - en re-asserted restarts with clk_q rising at that edge and tick = 1.
- Assert rst_n low while clk_q is high, N = 5:
  - clk_q = 0 immediately.
  - After release: n_act = 3, state IDLE, ratio_pending = 0.

Source files
------------

// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable 50%-duty clock divider:
// default widths, the ratio floor and the run-control state encoding.
package clk_div_prog_pkg;

    localparam int W_DEFAULT = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the divider: run enable, ratio request and divided outputs.
interface clk_div_prog_if
    import clk_div_prog_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         en;
    logic [W-1:0] div_ratio;
    logic         ratio_load;
    logic         clk_q;
    logic         tick;
    logic         ratio_pending;

    modport master (
        output en, div_ratio, ratio_load,
        input  clk_q, tick, ratio_pending
    );

    modport slave (
        input  en, div_ratio, ratio_load,
        output clk_q, tick, ratio_pending
    );
endinterface

// File: rtl/clk_div_phase.sv
// Dual-edge output stage: a rising-edge high term plus a falling-edge copy that
// stretches odd ratios by half a cycle, merged by a single OR of registered terms.
module clk_div_phase
    import clk_div_prog_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] n_act,
    input  logic         run,
    output logic         clk_q
);
    logic p;
    logic odd;
    logic n;

    // n_act >> 1 is N/2 for even N and (N-1)/2 for odd N, the rising-edge high span in both cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= 1'b0;
            odd <= 1'b0;
        end else begin
            p   <= run && (cnt < (n_act >> 1));
            odd <= n_act[0];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 1'b0;
        end else begin
            n <= p & odd;
        end
    end

    assign clk_q = p | n;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: run-control FSM, period counter and
// boundary-aligned ratio shadowing; the output waveform comes from clk_div_phase.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int DEFAULT_DIV = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_prog_if.slave  bus
);
    localparam logic [W-1:0] DEF_N = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_N = W'(MIN_DIV);
    localparam logic [W-1:0] ONE   = W'(1);

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] n_act, n_act_nxt;
    logic [W-1:0] n_pend, n_pend_nxt;
    logic         pending, pending_nxt;
    logic         tick, tick_nxt;
    logic         wrap;
    logic         apply;

    assign wrap  = (state != IDLE) && (cnt == n_act - ONE);
    assign apply = (state == IDLE) || wrap;

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        n_act_nxt   = n_act;
        n_pend_nxt  = n_pend;
        pending_nxt = pending;
        tick_nxt    = 1'b0;

        if (apply && pending) begin
            n_act_nxt   = n_pend;
            pending_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.en) begin
                    state_nxt = RUN;
                    tick_nxt  = 1'b1;
                end
            end
            RUN, STOPPING: begin
                if (wrap) begin
                    cnt_nxt = '0;
                    if (bus.en) begin
                        state_nxt = RUN;
                        tick_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt   = cnt + ONE;
                    state_nxt = bus.en ? RUN : STOPPING;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A load on a boundary edge lands in n_pend after the old value was applied above.
        if (bus.ratio_load) begin
            n_pend_nxt  = (bus.div_ratio < MIN_N) ? MIN_N : bus.div_ratio;
            pending_nxt = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            n_act   <= DEF_N;
            n_pend  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            n_act   <= n_act_nxt;
            n_pend  <= n_pend_nxt;
            pending <= pending_nxt;
            tick    <= tick_nxt;
        end
    end

    // Next-state values feed the phase stage so its registered term changes on the same edge as cnt.
    clk_div_phase #(.W(W)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_nxt),
        .n_act (n_act_nxt),
        .run   (state_nxt != IDLE),
        .clk_q (bus.clk_q)
    );

    assign bus.tick          = tick;
    assign bus.ratio_pending = pending;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a period/half-slot model checked every
// half cycle, directed scenarios with literal waveform pins, then random traffic.
module tb_clk_div_prog;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_div_prog_if #(.W(W)) bus ();

    clk_div_prog #(.W(W), .DEFAULT_DIV(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a period of N cycles is 2N half-slots; clk_q is high in the first N of them.
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_n    = 3;
    int m_pn   = 0;
    bit m_pend = 1'b0;
    bit m_tick = 1'b0;

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_n    = 3;
        m_pn   = 0;
        m_pend = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit load, input int ratio);
        bit start;
        start = 1'b0;
        if (!m_run || m_pos == m_n - 1) begin
            if (m_pend) begin
                m_n    = m_pn;
                m_pend = 1'b0;
            end
            m_pos = 0;
            m_run = en;
            start = en;
        end else begin
            m_pos++;
        end
        if (load) begin
            m_pn   = (ratio < 2) ? 2 : ratio;
            m_pend = 1'b1;
        end
        m_tick = start;
    endtask

    function automatic logic exp_q(input int half);
        return m_run && (2 * m_pos + half < m_n);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step(bus.en, bus.ratio_load, int'(bus.div_ratio));
        #1;
        if (rst_n) begin
            check("tick", bus.tick, m_tick);
            check("ratio_pending", bus.ratio_pending, m_pend);
            check("clk_q_first_half", bus.clk_q, exp_q(0));
        end
        @(negedge clk);
        #1;
        if (rst_n) check("clk_q_second_half", bus.clk_q, exp_q(1));
    end

    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    // Waits until a period starts with no ratio outstanding; returns at the start of its cnt=0 cycle.
    task automatic wait_applied(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.tick && !bus.ratio_pending) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    // Literal N=3 waveform from an IDLE start: high 1.5 cycles, low 1.5 cycles, tick every 3.
    task automatic start_seq_n3(input string tag);
        @(posedge clk); #1;
        check({tag, "_c0_tick"}, bus.tick, 1);
        check({tag, "_c0_hi"}, bus.clk_q, 1);
        @(negedge clk); #1;
        check({tag, "_c0_lo"}, bus.clk_q, 1);
        @(posedge clk); #1;
        check({tag, "_c1_tick"}, bus.tick, 0);
        check({tag, "_c1_hi"}, bus.clk_q, 1);
        @(negedge clk); #1;
        check({tag, "_c1_lo"}, bus.clk_q, 0);
        @(posedge clk); #1;
        check({tag, "_c2_hi"}, bus.clk_q, 0);
        @(negedge clk); #1;
        check({tag, "_c2_lo"}, bus.clk_q, 0);
        @(posedge clk); #1;
        check({tag, "_c3_tick"}, bus.tick, 1);
        check({tag, "_c3_hi"}, bus.clk_q, 1);
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.ratio_load = 1'b0;
        bus.div_ratio  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_q", bus.clk_q, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_pending", bus.ratio_pending, 0);
        nxt(); rst_n = 1'b1;
        repeat (3) nxt();

        bus.en = 1'b1;
        start_seq_n3("n3");

        // Load 4 mid-period: the 3-cycle period completes, then high 2 / low 2.
        nxt(); bus.ratio_load = 1'b1; bus.div_ratio = 8'd4;
        @(posedge clk); #1;
        check("load4_pending", bus.ratio_pending, 1);
        nxt(); bus.ratio_load = 1'b0;
        wait_applied("load4_applied");
        @(posedge clk); #1;
        check("n4_c1_hi", bus.clk_q, 1);
        @(negedge clk); #1;
        check("n4_c1_lo", bus.clk_q, 1);
        @(posedge clk); #1;
        check("n4_c2_hi", bus.clk_q, 0);

        // Loads 6 then 5 within one period: only 5 takes effect.
        nxt(); bus.ratio_load = 1'b1; bus.div_ratio = 8'd6;
        nxt(); bus.div_ratio = 8'd5;
        nxt(); bus.ratio_load = 1'b0;
        wait_applied("load5_applied");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("n5_c2_hi", bus.clk_q, 1);
        @(negedge clk); #1;
        check("n5_c2_lo", bus.clk_q, 0);

        // Ratios 0 and 1 clamp to 2.
        for (int r = 0; r < 2; r++) begin
            nxt(); bus.ratio_load = 1'b1; bus.div_ratio = W'(r);
            nxt(); bus.ratio_load = 1'b0;
            wait_applied("clamp_applied");
            @(negedge clk); #1;
            check("n2_c0_lo", bus.clk_q, 1);
            @(posedge clk); #1;
            check("n2_c1_hi", bus.clk_q, 0);
            check("n2_c1_tick", bus.tick, 0);
            @(posedge clk); #1;
            check("n2_c2_tick", bus.tick, 1);
        end

        // N=8, en dropped while cnt=1: period completes, then clk_q stays low.
        nxt(); bus.ratio_load = 1'b1; bus.div_ratio = 8'd8;
        nxt(); bus.ratio_load = 1'b0;
        wait_applied("load8_applied");
        nxt();
        nxt(); bus.en = 1'b0;
        repeat (12) nxt();
        check("stop_clk_q", bus.clk_q, 0);
        check("stop_tick", bus.tick, 0);
        bus.en = 1'b1;
        @(posedge clk); #1;
        check("restart_clk_q", bus.clk_q, 1);
        check("restart_tick", bus.tick, 1);

        for (int i = 0; i < 400; i++) begin
            nxt();
            bus.en         = ($urandom_range(0, 9) != 0);
            bus.ratio_load = ($urandom_range(0, 7) == 0);
            bus.div_ratio  = W'($urandom_range(0, 12));
        end

        // Asynchronous reset while clk_q is high with N=5.
        nxt(); bus.en = 1'b1; bus.ratio_load = 1'b1; bus.div_ratio = 8'd5;
        nxt(); bus.ratio_load = 1'b0;
        wait_applied("pre_rst_applied");
        check("pre_rst_clk_q", bus.clk_q, 1);
        #2;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        #1;
        check("rst_async_clk_q", bus.clk_q, 0);
        check("rst_async_tick", bus.tick, 0);
        repeat (2) nxt();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pending", bus.ratio_pending, 0);
        check("post_rst_clk_q", bus.clk_q, 0);
        nxt(); bus.en = 1'b1;
        start_seq_n3("post_rst");

        repeat (5) nxt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
